// File: rtl/jtframe_deserializer.sv
// jtframe_deserializer: start/data/parity serial frame receiver clocked by an external sclk.
// Optional frame timeout enabled by defining JTFRAME_DESER_TIMEOUT_EN.
module jtframe_deserializer #(
  parameter int DW   = 8,
  parameter int PAR  = 1,
  parameter int TOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          sdin,
  output logic [DW-1:0] dout,
  output logic          dvalid,
  output logic          perr,
  output logic          busy,
  output logic          tout
);
  localparam int CW = $clog2(DW + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
  state_t        st;
  logic [1:0]    sclk_s, sdin_s;
  logic          sclk_d, fall, bit_s;
  logic [CW-1:0] cnt;
  logic [DW-1:0] shreg;
  if (DW < 1 || TOUT < 2) begin : g_bad
    $error("jtframe_deserializer: DW must be >= 1 and TOUT >= 2");
  end
  // The registered fall pulse puts dvalid three clk edges after the input sees sclk drop
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s <= 2'b00;
      sdin_s <= 2'b11;
      sclk_d <= 1'b0;
      fall   <= 1'b0;
      bit_s  <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[0], sclk};
      sdin_s <= {sdin_s[0], sdin};
      sclk_d <= sclk_s[1];
      fall   <= sclk_d & ~sclk_s[1];
      bit_s  <= sdin_s[1];
    end
  end
  assign busy = st != IDLE;
`ifdef JTFRAME_DESER_TIMEOUT_EN
  localparam int TW = $clog2(TOUT + 1);
  logic [TW-1:0] tcnt;
`else
  assign tout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      cnt    <= '0;
      shreg  <= '0;
      dout   <= '0;
      dvalid <= 1'b0;
      perr   <= 1'b0;
`ifdef JTFRAME_DESER_TIMEOUT_EN
      tcnt   <= '0;
      tout   <= 1'b0;
`endif
    end else begin
      dvalid <= 1'b0;
      if (fall) begin
        case (st)
          IDLE: if (!bit_s) begin
            st  <= DATA;
            cnt <= '0;
          end
          DATA: begin
            shreg <= {bit_s, shreg[DW-1:1]};
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(DW - 1)) st <= PARITY;
          end
          default: begin
            dout   <= shreg;
            dvalid <= 1'b1;
            perr   <= bit_s != (^shreg ^ PAR[0]);
            st     <= IDLE;
          end
        endcase
      end
`ifdef JTFRAME_DESER_TIMEOUT_EN
      tout <= 1'b0;
      // A fall never coincides with the abort, so the FSM update above is never overridden mid-sample
      if (fall || st == IDLE) tcnt <= '0;
      else if (tcnt == TW'(TOUT - 1)) begin
        st   <= IDLE;
        tout <= 1'b1;
        tcnt <= '0;
      end else tcnt <= tcnt + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_jtframe_deserializer.sv
// tb_jtframe_deserializer: table, directed and random frame checks against a parity model.
module tb_jtframe_deserializer;
  localparam int DW = 8, PAR = 1, TOUT = 64;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, sdin = 1'b1;
  logic [DW-1:0] dout;
  logic dvalid, perr, busy, tout;
  int vectors = 0, miscompares = 0, touts = 0, half = 4;
  logic [DW:0] got[$], expq[$];
  typedef struct {
    logic [DW-1:0] data;
    logic          pbit;
    logic [DW-1:0] exp_dout;
    logic          exp_perr;
  } vec_t;
  vec_t tbl[8];
  jtframe_deserializer #(.DW(DW), .PAR(PAR), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sdin(sdin),
    .dout(dout), .dvalid(dvalid), .perr(perr), .busy(busy), .tout(tout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (dvalid) got.push_back({perr, dout});
    if (tout) touts++;
  end
  function automatic logic [DW:0] model(input logic [DW-1:0] d, input logic p);
    return {(($countones(d) + int'(p)) % 2) != PAR, d};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic expect_frame(input string name, input logic [DW:0] exp);
    logic [DW:0] v;
    if (got.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no frame received, expected dout %0h perr %0b", name, exp[DW-1:0], exp[DW]);
    end else begin
      v = got.pop_front();
      check({name, "_dout"}, 32'(v[DW-1:0]), 32'(exp[DW-1:0]));
      check({name, "_perr"}, 32'(v[DW]), 32'(exp[DW]));
    end
  endtask
  task automatic send_bit(input logic b);
    @(negedge clk);
    sdin = b;
    sclk = 1'b1;
    repeat (half) @(negedge clk);
    sclk = 1'b0;
    repeat (half) @(negedge clk);
  endtask
  task automatic send_frame(input logic [DW-1:0] d, input logic p);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    send_bit(p);
  endtask
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int n;
    logic seen;
    logic [DW-1:0] d;
    logic p;
    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'hA5, 1'b0, 8'hA5, 1'b1};
    tbl[2] = '{8'h3C, 1'b1, 8'h3C, 1'b0};
    tbl[3] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    tbl[5] = '{8'h5A, 1'b0, 8'h5A, 1'b1};
    tbl[6] = '{8'h01, 1'b0, 8'h01, 1'b0};
    tbl[7] = '{8'h80, 1'b1, 8'h80, 1'b1};
    repeat (4) @(negedge clk);
    check("rst_dout", 32'(dout), 0);
    check("rst_dvalid", 32'(dvalid), 0);
    check("rst_perr", 32'(perr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tout", 32'(tout), 0);
    rst = 1'b0;
    settle(4);
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].data, tbl[i].pbit);
      settle(8);
      check($sformatf("tbl%0d_count", i), got.size(), 1);
      expect_frame($sformatf("tbl%0d", i), {tbl[i].exp_perr, tbl[i].exp_dout});
      check($sformatf("tbl%0d_hold_dout", i), 32'(dout), 32'(tbl[i].exp_dout));
      check($sformatf("tbl%0d_hold_perr", i), 32'(perr), 32'(tbl[i].exp_perr));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 0);
    end
    d = 8'h3C;
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    @(negedge clk);
    sdin = 1'b1;
    sclk = 1'b1;
    repeat (half) @(negedge clk);
    sclk = 1'b0;
    n = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      seen = dvalid;
    end
    check("latency", n, 4);
    @(posedge clk);
    #1;
    check("dvalid_pulse", 32'(dvalid), 0);
    settle(8);
    expect_frame("lat", {1'b0, 8'h3C});
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    settle(8);
    check("b2b_count", got.size(), 2);
    expect_frame("b2b0", {1'b0, 8'h00});
    expect_frame("b2b1", {1'b0, 8'hFF});
    d = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    @(negedge clk);
    rst = 1'b1;
    settle(2);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_dout", 32'(dout), 0);
    send_frame(8'h5A, 1'b1);
    settle(8);
    check("midrst_count", got.size(), 1);
    expect_frame("midrst", {1'b0, 8'h5A});
    repeat (100) @(negedge clk) sdin = ~sdin;
    sdin = 1'b1;
    settle(4);
    check("toggle_busy", 32'(busy), 0);
    check("toggle_count", got.size(), 0);
    for (int k = 0; k < 40; k++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      half = $urandom_range(3, 6);
      expq.push_back(model(d, p));
      send_frame(d, p);
      repeat ($urandom_range(0, 2)) send_bit(1'b1);
    end
    half = 4;
    settle(10);
    check("rnd_count", got.size(), expq.size());
    for (int k = 0; expq.size() > 0; k++) expect_frame($sformatf("rnd%0d", k), expq.pop_front());
    send_frame(8'hC3, 1'b1);
    settle(8);
    expect_frame("pre_stall", {1'b0, 8'hC3});
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    sdin = 1'b1;
    sclk = 1'b1;
    repeat (half) @(negedge clk);
    sclk = 1'b0;
`ifdef JTFRAME_DESER_TIMEOUT_EN
    n = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      seen = tout;
    end
    if (!(seen && n >= 64 && n <= 70)) begin
      vectors++;
      miscompares++;
      $display("FAIL tout_latency: tout after %0d cycles (seen=%0b), expected 64..70", n, seen);
    end else vectors++;
    @(negedge clk);
    check("tout_busy", 32'(busy), 0);
    check("tout_dout", 32'(dout), 32'h000000C3);
    check("tout_perr", 32'(perr), 0);
    send_frame(8'h81, 1'b1);
    settle(8);
    expect_frame("post_tout", {1'b0, 8'h81});
    check("tout_pulses", touts, 1);
`else
    settle(200);
    check("stall_busy", 32'(busy), 1);
    check("stall_count", got.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    settle(2);
    rst = 1'b0;
    send_frame(8'h81, 1'b1);
    settle(8);
    expect_frame("post_stall", {1'b0, 8'h81});
    check("tout_pulses", touts, 0);
`endif
    check("leftover", got.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jtframe_deserializer.md
JTFRAME_DESERIALIZER -- requirements
Module: jtframe_deserializer

Interface
REQ-001 Parameter DW, default 8: number of data bits per frame.
REQ-002 Parameter PAR, default 1: parity sense; 1 = odd, 0 = even.
REQ-003 Parameter TOUT, default 1024: timeout length in clk cycles; used only with the Configuration feature.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sclk  input  1  serial clock from the transmitter; asynchronous to clk; idles low.
REQ-007 sdin  input  1  serial data; idles high; changes on sclk rising edges.
REQ-008 dout  output  DW  last received data word.
REQ-009 dvalid  output  1  one-clk pulse when dout updates.
REQ-010 perr  output  1  parity error of the frame last delivered on dout.
REQ-011 busy  output  1  high while a frame is in progress (state not IDLE).
REQ-012 tout  output  1  one-clk pulse when a frame is aborted by timeout.

Function
REQ-013 Frame format on the wire: start bit 0, DW data bits LSB first, one parity bit; the line idles at 1; no stop bit is guaranteed, and the next start bit may immediately follow parity.
REQ-014 sclk and sdin each pass through a two-flop synchronizer; a falling edge is detected from the synchronized sclk and its one-cycle-delayed copy.
REQ-015 sdin is sampled only on detected sclk falling edges; all other clk cycles leave state unchanged.
REQ-016 State machine has three states: IDLE, DATA, PARITY.
REQ-017 IDLE: a sampled 0 moves to DATA and clears the bit counter; a sampled 1 stays in IDLE.
REQ-018 DATA: each sample shifts in from the MSB side (shreg <= {s, shreg[DW-1:1]}); after the DW-th sample, move to PARITY.
REQ-019 PARITY: on the sample, dout <= shreg; dvalid pulses for exactly one clk; perr <= (s != (^shreg ^ PAR[0])); move to IDLE.
REQ-020 A frame with a parity error is still delivered: dout updates and dvalid pulses with perr=1.
REQ-021 perr holds its value until the next dvalid; dout holds its value until the next dvalid.
REQ-022 Latency: the clk edge that registers the final sclk fall at the input is followed by dvalid high exactly 3 clk edges later.
REQ-023 The bit counter is $clog2(DW+1) bits wide; no wrap occurs within a frame.
REQ-024 A start bit sampled on the first sclk fall after PARITY begins a new frame without loss (back-to-back frames).
REQ-025 An sdin change without an sclk falling edge has no effect.
REQ-026 sclk must stay in each phase for at least 3 clk cycles; behaviour with faster sclk is undefined.

Reset
REQ-027 rst returns the state machine to IDLE and clears the bit counter and shreg.
REQ-028 rst clears dout, dvalid, perr and tout.
REQ-029 rst sets the sclk synchronizer to 0 and the sdin synchronizer to 1.
REQ-030 rst asserted mid-frame discards the partial frame; dvalid is not pulsed for it.

Configuration
REQ-031 Macro JTFRAME_DESER_TIMEOUT_EN controls the frame timeout.
REQ-032 With the macro defined: a counter clears on every sclk falling edge and in IDLE, and increments each clk while busy; on reaching TOUT, the state returns to IDLE, tout pulses for one clk, and dout, dvalid and perr are untouched.
REQ-033 With the macro undefined: no timeout counter exists, tout is tied to 0, and a stalled frame waits indefinitely.

Verification
REQ-034 DW=8, PAR=1, frame 0,1,0,1,0,0,1,0,1,1 (0xA5, parity 1) -> dvalid pulse, dout=0xA5, perr=0.
REQ-035 Same frame with parity bit 0 -> dout=0xA5, perr=1; a following good frame of 0x3C (parity 1) -> perr=0.
REQ-036 Back-to-back frames 0x00 (parity 1) then 0xFF (parity 1) with no idle bit -> two dvalid pulses, dout=0x00 then 0xFF, perr=0 for both.
REQ-037 rst asserted after 4 data bits, then a full 0x5A frame -> a single dvalid, with dout=0x5A.
REQ-038 sdin toggled with sclk held low for 100 clk -> busy=0, no dvalid.
REQ-039 With JTFRAME_DESER_TIMEOUT_EN and TOUT=64: sclk stops after 3 data bits -> tout pulses 64 clk after the last edge, busy=0; the next 0x81 frame is received correctly.
